// File: rtl/pdm_modulator.sv
// PCM-to-PDM transmit path: input FIFO, zero-order-hold interpolation, 2nd-order sigma-delta.
// Optional quantizer dither is compiled in when PDM_DITHER_EN is defined.
module pdm_modulator #(
    parameter int DW         = 16,
    parameter int ACCW       = 24,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clk_en,
    input  logic [15:0]                 rate,
    input  logic                        rate_we,
    input  logic [DW-1:0]               din,
    input  logic                        din_valid,
    output logic                        din_ready,
    output logic                        pdm_out,
    output logic                        pdm_valid,
    output logic                        underrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int XW = ACCW + 2;
    localparam logic signed [XW-1:0] SAT_MAX = {3'b000, {(ACCW-1){1'b1}}};
    localparam logic signed [XW-1:0] SAT_MIN = {3'b111, {(ACCW-1){1'b0}}};
    localparam logic signed [XW-1:0] FB_POS  = {{(XW-DW){1'b0}}, 1'b1, {(DW-1){1'b0}}};
    localparam logic signed [XW-1:0] FB_NEG  = -FB_POS;

    logic [DW-1:0]          mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          count_q, count_d;
    logic                   din_ready_q, din_ready_d;
    logic [15:0]            rate_num_q, rate_num_d;
    logic [15:0]            phase_q, phase_d;
    logic [DW-1:0]          hold_q, hold_d;
    logic signed [ACCW-1:0] i1_q, i1_d;
    logic signed [ACCW-1:0] i2_q, i2_d;
    logic                   pdm_q, pdm_d;
    logic                   pdm_valid_q, pdm_valid_d;
    logic                   underrun_q, underrun_d;

    logic                   push, pop, fetch;
    logic [15:0]            rate_eff;
    logic signed [XW-1:0]   x_ext, fb, i1_sum, i2_sum, q_in, dither;
    logic signed [ACCW-1:0] i1_new, i2_new;

    function automatic logic signed [ACCW-1:0] sat(input logic signed [XW-1:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[ACCW-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[ACCW-1:0];
        end else begin
            return v[ACCW-1:0];
        end
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_q == AW'(gi))) begin
                    mem_q[gi] <= din;
                end
            end
        end
    endgenerate

`ifdef PDM_DITHER_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (clk_en) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
        dither = lfsr_q[0] ? {{(XW-1){1'b0}}, 1'b1} : {XW{1'b1}};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign dither = '0;
`endif

    always_comb begin
        push     = din_valid && din_ready_q;
        // A write in this cycle never satisfies a fetch: pop only sees the stored level.
        rate_eff = rate_we ? rate : rate_num_q;
        fetch    = clk_en && (phase_q >= rate_eff);
        pop      = fetch && (count_q != '0);

        x_ext  = {{(XW-DW){hold_q[DW-1]}}, hold_q};
        fb     = pdm_q ? FB_POS : FB_NEG;
        i1_sum = {{2{i1_q[ACCW-1]}}, i1_q} + x_ext - fb;
        i1_new = sat(i1_sum);
        i2_sum = {{2{i2_q[ACCW-1]}}, i2_q} + {{2{i1_new[ACCW-1]}}, i1_new} - fb;
        i2_new = sat(i2_sum);
        q_in   = {{2{i2_new[ACCW-1]}}, i2_new} + dither;

        wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d     = count_q + LW'(push) - LW'(pop);
        din_ready_d = (count_d != LW'(FIFO_DEPTH));
        rate_num_d  = rate_eff;
        phase_d     = phase_q;
        hold_d      = hold_q;
        i1_d        = i1_q;
        i2_d        = i2_q;
        pdm_d       = pdm_q;
        pdm_valid_d = clk_en;
        underrun_d  = fetch && !pop;

        if (clk_en) begin
            phase_d = fetch ? 16'd0 : phase_q + 16'd1;
            i1_d    = i1_new;
            i2_d    = i2_new;
            pdm_d   = ~q_in[XW-1];
        end
        if (pop) begin
            hold_d = mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            din_ready_q <= 1'b0;
            rate_num_q  <= '0;
            phase_q     <= '0;
            hold_q      <= '0;
            i1_q        <= '0;
            i2_q        <= '0;
            pdm_q       <= 1'b0;
            pdm_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            din_ready_q <= din_ready_d;
            rate_num_q  <= rate_num_d;
            phase_q     <= phase_d;
            hold_q      <= hold_d;
            i1_q        <= i1_d;
            i2_q        <= i2_d;
            pdm_q       <= pdm_d;
            pdm_valid_q <= pdm_valid_d;
            underrun_q  <= underrun_d;
        end
    end

    assign din_ready  = din_ready_q;
    assign pdm_out    = pdm_q;
    assign pdm_valid  = pdm_valid_q;
    assign underrun   = underrun_q;
    assign fifo_level = count_q;

endmodule
